// File: rtl/psum_out_pkg.sv
`default_nettype none
// ============================================================================
// Module  : psum_out_pkg
// Brief   : Shared widths, lane order and 10->8 bit saturation for psum output.
// Revision: 1.0
// ============================================================================
package psum_out_pkg;

    localparam int PSUM_W = 10;
    localparam int OUT_W  = 8;
    localparam int LANES  = 3;

    // Push order into the FIFO: PE 2,0 (lane 2) first, PE 2,2 (lane 0) last
    localparam int LANE_ORDER [LANES] = '{2, 1, 0};

    function automatic logic [OUT_W-1:0] sat8(input logic signed [PSUM_W-1:0] v);
        if (v > PSUM_W'(127)) begin
            return 8'h7f;
        end else if (v < PSUM_W'(-128)) begin
            return 8'h80;
        end else begin
            return v[OUT_W-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/psum_mpush_fifo.sv
`default_nettype none
// ============================================================================
// Module  : psum_mpush_fifo
// Brief   : Show-ahead FIFO accepting 0..3 writes and 0..1 read per cycle.
// Revision: 1.0
// ============================================================================
module psum_mpush_fifo
    import psum_out_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      nRST,
    input  logic                      i_clear,
    input  logic [LANES-1:0]          i_wr_en,
    input  logic [LANES*OUT_W-1:0]    i_wr_data,
    input  logic                      i_rd_en,
    output logic [OUT_W-1:0]          o_rd_data,
    output logic [$clog2(DEPTH):0]    o_level,
    output logic [1:0]                o_push_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [OUT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;

    logic [AW:0]      w_free;
    logic [AW:0]      w_ofs;
    logic [LANES-1:0] w_acc;
    logic [AW-1:0]    w_idx [LANES];
    logic [1:0]       w_push_cnt;

    // A pop frees its slot in the same cycle, so a full FIFO can still take one write
    always_comb begin
        w_free     = (AW+1)'(DEPTH) - r_level + {{AW{1'b0}}, i_rd_en};
        w_ofs      = '0;
        w_push_cnt = '0;
        w_acc      = '0;
        for (int k = 0; k < LANES; k++) begin
            w_idx[k] = '0;
        end
        for (int k = 0; k < LANES; k++) begin
            if (i_wr_en[LANE_ORDER[k]]) begin
                if (w_ofs < w_free) begin
                    w_acc[LANE_ORDER[k]] = 1'b1;
                    w_idx[LANE_ORDER[k]] = r_wr_ptr + w_ofs[AW-1:0];
                    w_push_cnt           = w_push_cnt + 2'd1;
                end
                w_ofs = w_ofs + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push_cnt);
            r_rd_ptr <= r_rd_ptr + AW'(i_rd_en);
            r_level  <= r_level + (AW+1)'(w_push_cnt) - (AW+1)'(i_rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (!i_clear) begin
            for (int k = 0; k < LANES; k++) begin
                if (w_acc[k]) begin
                    r_mem[w_idx[k]] <= i_wr_data[k*OUT_W +: OUT_W];
                end
            end
        end
    end

    // Storage is not reset; gating on occupancy gives a defined zero when empty
    assign o_rd_data  = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_level    = r_level;
    assign o_push_cnt = (i_clear) ? 2'd0 : w_push_cnt;

endmodule
`default_nettype wire

// File: rtl/psum_out_buffer.sv
`default_nettype none
// ============================================================================
// Module  : psum_out_buffer
// Brief   : Saturates bottom-row PE partial sums and drains them via a FIFO.
// Revision: 1.0
// ============================================================================
module psum_out_buffer
    import psum_out_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      nRST,
    input  logic [LANES*PSUM_W-1:0]   psum_i,
    input  logic [LANES-1:0]          psum_valid_i,
    input  logic                      clear_i,
    output logic [OUT_W-1:0]          write_o,
    output logic                      write_valid_o,
    input  logic                      write_ready_i,
    output logic                      overflow_o,
    output logic [CNT_W-1:0]          out_count_o,
    output logic [$clog2(DEPTH):0]    level_o
);

    logic [LANES*OUT_W-1:0] w_sat;
    logic                   w_pop;
    logic [1:0]             w_push_cnt;
    logic [1:0]             w_valid_cnt;
    logic                   w_drop;
    logic                   r_overflow;
    logic [CNT_W-1:0]       r_out_count;

    for (genvar k = 0; k < LANES; k++) begin : g_lane_sat
        assign w_sat[k*OUT_W +: OUT_W] = sat8(psum_i[k*PSUM_W +: PSUM_W]);
    end

    assign write_valid_o = (level_o != '0);
    assign w_pop         = write_valid_o && write_ready_i;

    psum_mpush_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .nRST       (nRST),
        .i_clear    (clear_i),
        .i_wr_en    (psum_valid_i),
        .i_wr_data  (w_sat),
        .i_rd_en    (w_pop),
        .o_rd_data  (write_o),
        .o_level    (level_o),
        .o_push_cnt (w_push_cnt)
    );

    // Any valid lane the FIFO did not take counts as a drop
    assign w_valid_cnt = 2'(psum_valid_i[0]) + 2'(psum_valid_i[1]) + 2'(psum_valid_i[2]);
    assign w_drop      = !clear_i && (w_valid_cnt != w_push_cnt);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_overflow  <= 1'b0;
            r_out_count <= '0;
        end else if (clear_i) begin
            r_overflow  <= 1'b0;
            r_out_count <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_out_count <= r_out_count + CNT_W'(1);
            end
        end
    end

    assign overflow_o  = r_overflow;
    assign out_count_o = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_psum_out_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_psum_out_buffer
// Brief   : Scoreboard bench for psum_out_buffer with directed vectors.
// Revision: 1.0
// ============================================================================
module tb_psum_out_buffer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             nRST = 1'b0;
    logic [29:0]      psum_i = '0;
    logic [2:0]       psum_valid_i = '0;
    logic             clear_i = 1'b0;
    logic             write_ready_i = 1'b0;
    logic [7:0]       write_o;
    logic             write_valid_o;
    logic             overflow_o;
    logic [CNT_W-1:0] out_count_o;
    logic [3:0]       level_o;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] expq [$];

    logic       r_hold_prev = 1'b0;
    logic       r_clr_prev  = 1'b0;
    logic [7:0] r_hold_data = '0;

    psum_out_buffer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .nRST          (nRST),
        .psum_i        (psum_i),
        .psum_valid_i  (psum_valid_i),
        .clear_i       (clear_i),
        .write_o       (write_o),
        .write_valid_o (write_valid_o),
        .write_ready_i (write_ready_i),
        .overflow_o    (overflow_o),
        .out_count_o   (out_count_o),
        .level_o       (level_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input int a2, input int a1, input int a0);
        psum_i       = {10'(a2), 10'(a1), 10'(a0)};
        psum_valid_i = v;
    endtask

    // Monitor: pops the scoreboard on every accepted byte and checks hold stability
    always @(negedge clk) begin
        if (nRST) begin
            if (r_hold_prev && !r_clr_prev) begin
                chk("hold_valid", int'(write_valid_o), 1);
                chk("hold_data", int'(write_o), int'(r_hold_data));
            end
            if (write_valid_o && write_ready_i) begin
                if (expq.size() == 0) begin
                    chk("unexpected_out", int'(write_o), -1);
                end else begin
                    chk("out_data", int'(write_o), int'(expq.pop_front()));
                end
            end
            r_hold_prev = write_valid_o && !write_ready_i;
            r_hold_data = write_o;
            r_clr_prev  = clear_i;
        end else begin
            r_hold_prev = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick;
        tick;
        chk("rst_level", int'(level_o), 0);
        chk("rst_valid", int'(write_valid_o), 0);
        chk("rst_data", int'(write_o), 0);
        chk("rst_ovf", int'(overflow_o), 0);
        chk("rst_count", int'(out_count_o), 0);
        nRST = 1'b1;
        tick;

        // Single lane, zero-latency show-ahead
        drive(3'b100, 45, 0, 0);
        write_ready_i = 1'b1;
        expq.push_back(8'd45);
        tick;
        drive(3'b000, 0, 0, 0);
        chk("t1_valid", int'(write_valid_o), 1);
        chk("t1_data", int'(write_o), 45);
        tick;
        chk("t1_count", int'(out_count_o), 1);
        chk("t1_level", int'(level_o), 0);

        // Saturation
        write_ready_i = 1'b0;
        drive(3'b111, 300, -300, -128);
        expq.push_back(8'h7f);
        expq.push_back(8'h80);
        expq.push_back(8'h80);
        tick;
        drive(3'b000, 0, 0, 0);
        chk("sat_level", int'(level_o), 3);
        write_ready_i = 1'b1;
        repeat (3) tick;
        chk("sat_level_end", int'(level_o), 0);
        chk("sat_count", int'(out_count_o), 4);

        // Lane ordering
        drive(3'b111, 1, 2, 3);
        expq.push_back(8'd1);
        expq.push_back(8'd2);
        expq.push_back(8'd3);
        tick;
        drive(3'b000, 0, 0, 0);
        repeat (3) tick;
        chk("ord_level", int'(level_o), 0);
        chk("ord_count", int'(out_count_o), 7);

        // Overflow: third burst loses its last lane
        write_ready_i = 1'b0;
        drive(3'b111, 10, 11, 12);
        expq.push_back(8'd10); expq.push_back(8'd11); expq.push_back(8'd12);
        tick;
        drive(3'b111, 20, 21, 22);
        expq.push_back(8'd20); expq.push_back(8'd21); expq.push_back(8'd22);
        tick;
        chk("ovf_pre", int'(overflow_o), 0);
        drive(3'b111, 30, 31, 32);
        expq.push_back(8'd30); expq.push_back(8'd31);
        tick;
        chk("ovf_level", int'(level_o), 8);
        chk("ovf_flag", int'(overflow_o), 1);
        // Full with a pop: exactly one lane fits
        write_ready_i = 1'b1;
        drive(3'b111, 40, 41, 42);
        expq.push_back(8'd40);
        tick;
        drive(3'b000, 0, 0, 0);
        chk("full_pop_level", int'(level_o), 8);
        repeat (8) tick;
        chk("ovf_drain_level", int'(level_o), 0);
        chk("ovf_sticky", int'(overflow_o), 1);
        chk("ovf_count", int'(out_count_o), 16);
        clear_i = 1'b1;
        tick;
        clear_i = 1'b0;
        chk("clr1_ovf", int'(overflow_o), 0);
        chk("clr1_count", int'(out_count_o), 0);

        // Backpressure toggling, 10 entries
        write_ready_i = 1'b0;
        drive(3'b111, 50, 51, 52);
        expq.push_back(8'd50); expq.push_back(8'd51); expq.push_back(8'd52);
        tick;
        write_ready_i = 1'b1;
        drive(3'b111, 53, 54, 55);
        expq.push_back(8'd53); expq.push_back(8'd54); expq.push_back(8'd55);
        tick;
        write_ready_i = 1'b0;
        drive(3'b111, 56, 57, 58);
        expq.push_back(8'd56); expq.push_back(8'd57); expq.push_back(8'd58);
        tick;
        write_ready_i = 1'b1;
        drive(3'b100, 59, 0, 0);
        expq.push_back(8'd59);
        tick;
        drive(3'b000, 0, 0, 0);
        chk("bp_level_mid", int'(level_o), 8);
        for (int i = 0; i < 40 && level_o != 0; i++) begin
            write_ready_i = ~write_ready_i;
            tick;
        end
        chk("bp_level", int'(level_o), 0);
        chk("bp_count", int'(out_count_o), 10);
        chk("bp_ovf", int'(overflow_o), 0);
        chk("bp_sb_empty", expq.size(), 0);

        // Clear beats simultaneous push
        write_ready_i = 1'b0;
        drive(3'b111, 60, 61, 62);
        tick;
        drive(3'b011, 0, 63, 64);
        tick;
        chk("clr_pre_level", int'(level_o), 5);
        clear_i = 1'b1;
        drive(3'b111, 70, 71, 72);
        tick;
        clear_i = 1'b0;
        drive(3'b000, 0, 0, 0);
        expq.delete();
        chk("clr_level", int'(level_o), 0);
        chk("clr_valid", int'(write_valid_o), 0);
        chk("clr_count", int'(out_count_o), 0);
        chk("clr_ovf", int'(overflow_o), 0);

        // Asynchronous reset mid-drain
        write_ready_i = 1'b1;
        drive(3'b111, 80, 81, 82);
        expq.push_back(8'd80); expq.push_back(8'd81); expq.push_back(8'd82);
        tick;
        drive(3'b000, 0, 0, 0);
        tick;
        chk("ar_level_pre", int'(level_o), 2);
        #2;
        nRST = 1'b0;
        expq.delete();
        #1;
        chk("ar_level", int'(level_o), 0);
        chk("ar_valid", int'(write_valid_o), 0);
        chk("ar_count", int'(out_count_o), 0);
        chk("ar_data", int'(write_o), 0);
        #1;
        nRST = 1'b1;
        tick;
        chk("ar_level_post", int'(level_o), 0);
        chk("final_sb_empty", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/psum_out_buffer.md
# psum_out_buffer

Output stage directly downstream of the 3x3 PE array. Captures the 10-bit partial sums from the three bottom-row PEs (PE 2,0 / 2,1 / 2,2) whenever their valid strobes fire, saturates each to 8-bit signed, and queues them in a multi-push FIFO. The FIFO drains one byte per cycle onto the 8-bit output pin under a valid/ready handshake, so simultaneous lane completions are never lost to a priority mux.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 4
- CNT_W, 8, width of the drained-output counter

Ports:
- clk  in  1  system clock
- nRST  in  1  asynchronous, active-low reset
- psum_i  in  3x10  signed partial sums; lane 2 = PE 2,0, lane 1 = PE 2,1, lane 0 = PE 2,2
- psum_valid_i  in  3  per-lane valid strobes, one cycle per result
- clear_i  in  1  synchronous flush: empties FIFO, zeroes counter, clears overflow
- write_o  out  8  signed saturated output byte (FIFO head)
- write_valid_o  out  1  head entry present
- write_ready_i  in  1  consumer accepts head this cycle
- overflow_o  out  1  sticky: at least one lane result dropped
- out_count_o  out  CNT_W  number of bytes accepted by the consumer, wraps modulo 2^CNT_W
- level_o  out  clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Saturation per lane: value > 127 -> 127; value < -128 -> -128; otherwise the low 8 bits. Two's complement throughout.
- Push: all lanes valid in a cycle are written in a single cycle, in fixed order lane 2, lane 1, lane 0, at consecutive slots from the tail.
- Pop: when write_valid_o && write_ready_i, the head advances and out_count_o increments.
- Free space in a cycle = DEPTH − level + (1 if pop this cycle). Pushes fill free space in lane order; lanes that do not fit are dropped and overflow_o is set (sticky until clear_i or reset).
- write_o is stable while write_valid_o=1 and write_ready_i=0.
- clear_i has priority over push and pop in the same cycle: the FIFO empties, out_count_o=0, overflow_o=0; lanes valid in that cycle are discarded.
- Pointers wrap modulo DEPTH; level_o is the only full/empty indicator (full = DEPTH, empty = 0).

## Timing
- Reset values: write_o=0, write_valid_o=0, overflow_o=0, out_count_o=0, level_o=0; pointers 0.
- Latency: a lane valid at edge N into an empty FIFO appears on write_o with write_valid_o=1 after edge N (visible in cycle N+1). Show-ahead output, no read latency.
- Throughput: up to 3 pushes and 1 pop per cycle; level_o updates by (pushes accepted − pop).
- Reset asserted mid-operation: all state cleared immediately, no pending entries survive.
- A pop and a push into the same slot in one cycle (FIFO full, one pop) is legal; the popped data is the old head.

## Structure
- Package psum_out_pkg: PSUM_W=10, OUT_W=8, LANES=3, the lane-order constant, and a pure function sat8 (10-bit signed -> 8-bit signed clamp).
- One sub-module: psum_mpush_fifo (DEPTH-entry FIFO with 0..3 writes and 0..1 read per cycle, reports level and accepted-push count). Top of this block instantiates three sat8 calls, the FIFO, overflow and counter logic.

## Test plan
- Single lane: psum_valid_i=3'b100, psum_i[2]=10'sd45, ready=1 -> next cycle write_o=45, write_valid_o=1; following cycle out_count_o=1, level_o=0.
- Saturation: lanes 2/1/0 = 300, −300, −128 in one cycle, ready=0 -> level_o=3; then ready=1 yields 127, −128, −128 on consecutive cycles.
- Simultaneous lanes ordering: valid=3'b111 with 1,2,3 -> output order 1,2,3 (lane 2 first).
- Overflow: DEPTH=8, ready=0, push 3 lanes for 3 cycles -> level_o=8, last lane dropped, overflow_o=1; with ready=1 on the full cycle pushing 3, exactly 1 accepted.
- Backpressure hold: ready toggled 0/1 every cycle for 10 entries -> write_o never changes while ready=0, out_count_o=10 at end, no loss.
- clear_i with valid=3'b111 and level_o=5 in same cycle -> next cycle level_o=0, write_valid_o=0, out_count_o=0, overflow_o=0; async nRST pulse mid-drain gives same result.
